// File: rtl/aemb_pkg.sv
// Shared types and constants for the aeMB instruction-side prefetch buffer.
package aemb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } aemb_pf_state_t;

  localparam int AEMB_IWB_INC = 4;

endpackage

// File: rtl/aemb_pf_fifo.sv
// Circular instruction buffer: DEPTH words, combinational head, flush clears
// pointers and count in one edge. A pop frees a slot for a same-edge push.
module aemb_pf_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   cnt,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/aemb_iwb_prefetch.sv
// Sequential instruction prefetcher between the aeMB IWB port and memory.
// IDLE: buffer full, or a miss just flushed it | FETCH: strobe at fadr | DRAIN: wait out a stale cycle
module aemb_iwb_prefetch
  import aemb_pkg::*;
#(
  parameter int ISIZ  = 32,
  parameter int DEPTH = 4
) (
  input  logic                   sys_clk_i,
  input  logic                   sys_rst_i,
  input  logic                   iwb_stb_i,
  input  logic [ISIZ-1:0]        iwb_adr_i,
  output logic [31:0]            iwb_dat_o,
  output logic                   iwb_ack_o,
  output logic                   mem_stb_o,
  output logic [ISIZ-1:0]        mem_adr_o,
  input  logic [31:0]            mem_dat_i,
  input  logic                   mem_ack_i,
  output logic [$clog2(DEPTH):0] pf_lvl_o
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [ISIZ-1:0] INC       = ISIZ'(AEMB_IWB_INC);
  localparam logic [LW-1:0]   LAST_SLOT = LW'(DEPTH - 1);

  aemb_pf_state_t  state;
  logic [ISIZ-1:0] hadr;
  logic [ISIZ-1:0] fadr;
  logic [ISIZ-1:0] fadr_nxt;
  logic [ISIZ-1:0] req_adr;
  logic [LW-1:0]   cnt;
  logic [31:0]     head;
  logic            full;
  logic            empty;
  logic            hit;
  logic            hold;
  logic            miss;
  logic            push;
  logic            pop;
  logic            fills_up;
  logic [1:0]      unused_adr_lsb;

  assign req_adr        = {iwb_adr_i[ISIZ-1:2], 2'b00};
  assign unused_adr_lsb = iwb_adr_i[1:0];
  assign fadr_nxt       = fadr + INC;

  // A request for the word still being fetched is neither hit nor miss.
  assign hit  = iwb_stb_i & ~iwb_ack_o & ~empty & (req_adr == hadr);
  assign hold = iwb_stb_i & empty & (req_adr == fadr);
  assign miss = iwb_stb_i & ~iwb_ack_o & ~hit & ~hold;

  assign pop      = hit;
  assign push     = (state == FETCH) & mem_ack_i & ~miss;
  assign fills_up = (cnt == LAST_SLOT) & ~pop;
  assign pf_lvl_o = cnt;

  aemb_pf_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (sys_clk_i),
    .rst   (sys_rst_i),
    .push  (push),
    .pop   (pop),
    .flush (miss),
    .din   (mem_dat_i),
    .dout  (head),
    .cnt   (cnt),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state     <= IDLE;
      hadr      <= '0;
      fadr      <= '0;
      iwb_ack_o <= 1'b0;
      iwb_dat_o <= '0;
      mem_stb_o <= 1'b0;
      mem_adr_o <= '0;
    end else begin
      iwb_ack_o <= hit;
      if (hit) begin
        iwb_dat_o <= head;
      end

      if (miss) begin
        hadr <= req_adr;
        fadr <= req_adr;
      end else begin
        if (hit) begin
          hadr <= hadr + INC;
        end
        if (push) begin
          fadr <= fadr_nxt;
        end
      end

      case (state)
        IDLE: begin
          if (!miss && !full) begin
            state     <= FETCH;
            mem_stb_o <= 1'b1;
            mem_adr_o <= fadr;
          end
        end
        FETCH: begin
          if (mem_ack_i) begin
            if (miss) begin
              mem_adr_o <= req_adr;
            end else if (fills_up) begin
              state     <= IDLE;
              mem_stb_o <= 1'b0;
            end else begin
              mem_adr_o <= fadr_nxt;
            end
          end else if (miss) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // The stale cycle must complete on the bus before the new one starts.
          if (mem_ack_i) begin
            state     <= FETCH;
            mem_adr_o <= miss ? req_adr : fadr;
          end
        end
        default: begin
          state     <= IDLE;
          mem_stb_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aemb_iwb_prefetch.sv
// Directed and randomized bench for aemb_iwb_prefetch: word data is address ^ K,
// so every acknowledged fetch can be checked against the requested address.
module tb_aemb_iwb_prefetch;

  localparam logic [31:0] K = 32'hA5A50000;

  logic        clk;
  logic        rst;
  logic        iwb_stb;
  logic [31:0] iwb_adr;
  logic [31:0] iwb_dat_o;
  logic        iwb_ack_o;
  logic        mem_stb_o;
  logic [31:0] mem_adr_o;
  logic [31:0] mem_dat;
  logic        mem_ack;
  logic [2:0]  pf_lvl_o;

  int          total;
  int          bad;
  int          ws;
  bit          ws_rand;
  logic [31:0] log_q[$];

  aemb_iwb_prefetch #(.ISIZ(32), .DEPTH(4)) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .iwb_stb_i (iwb_stb),
    .iwb_adr_i (iwb_adr),
    .iwb_dat_o (iwb_dat_o),
    .iwb_ack_o (iwb_ack_o),
    .mem_stb_o (mem_stb_o),
    .mem_adr_o (mem_adr_o),
    .mem_dat_i (mem_dat),
    .mem_ack_i (mem_ack),
    .pf_lvl_o  (pf_lvl_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: acks after ws wait states of a continuous strobe, data = addr ^ K.
  initial begin
    int  wcnt;
    bit  taken;
    wcnt = 0;
    taken = 0;
    mem_ack = 1'b0;
    mem_dat = '0;
    forever begin
      @(negedge clk);
      if (taken) begin
        wcnt = 0;
        if (ws_rand) ws = int'($urandom_range(3, 0));
      end
      if (mem_stb_o) begin
        mem_ack = (wcnt >= ws);
        mem_dat = mem_adr_o ^ K;
        wcnt++;
      end else begin
        mem_ack = 1'b0;
        wcnt = 0;
      end
      taken = mem_stb_o && mem_ack;
    end
  end

  // Log of every memory cycle the DUT completed.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst && mem_stb_o && mem_ack) log_q.push_back(mem_adr_o);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    iwb_stb = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    log_q.delete();
  endtask

  // Core fetch: strobe until ack, report data and number of edges taken, then one idle cycle.
  task automatic fetch(input logic [31:0] a, output logic [31:0] d, output int lat);
    iwb_adr = a;
    iwb_stb = 1'b1;
    lat = 0;
    d = '0;
    while (!iwb_ack_o && lat < 200) begin
      tick();
      lat++;
    end
    check($sformatf("ack_seen_%h", a), {31'b0, iwb_ack_o}, 32'd1);
    if (iwb_ack_o) d = iwb_dat_o;
    iwb_stb = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < log_q.size()) return log_q[i];
    return 32'hxxxxxxxx;
  endfunction

  initial begin
    logic [31:0] d;
    logic [31:0] a;
    logic [31:0] prev;
    int          lat;
    int          n;
    bit          early;

    total = 0;
    bad = 0;
    ws = 0;
    ws_rand = 0;
    rst = 1'b1;
    iwb_stb = 1'b0;
    iwb_adr = '0;

    // Reset values
    tick();
    check("rst_iwb_ack", {31'b0, iwb_ack_o}, 32'd0);
    check("rst_iwb_dat", iwb_dat_o, 32'd0);
    check("rst_mem_stb", {31'b0, mem_stb_o}, 32'd0);
    check("rst_mem_adr", mem_adr_o, 32'd0);
    check("rst_lvl", {29'b0, pf_lvl_o}, 32'd0);
    tick();
    rst = 1'b0;
    log_q.delete();

    // Zero-wait fill from reset: 0,4,8,C back to back then stop full
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("fill_stb_%0d", i), {31'b0, mem_stb_o}, 32'd1);
      check($sformatf("fill_adr_%0d", i), mem_adr_o, 32'(4 * i));
    end
    tick();
    check("fill_stb_drop", {31'b0, mem_stb_o}, 32'd0);
    check("fill_lvl_full", {29'b0, pf_lvl_o}, 32'd4);
    tick();
    check("full_no_fetch", {31'b0, mem_stb_o}, 32'd0);

    // Sequential hits
    for (int i = 0; i < 3; i++) begin
      fetch(32'(4 * i), d, lat);
      check($sformatf("hit_lat_%0d", i), lat, 32'd1);
      check($sformatf("hit_dat_%0d", i), d, 32'(4 * i) ^ K);
    end
    repeat (8) tick();
    check("refill_log_size", log_q.size(), 32'd7);
    for (int i = 0; i < 7; i++)
      check($sformatf("refill_adr_%0d", i), log_at(i), 32'(4 * i));
    check("refill_lvl", {29'b0, pf_lvl_o}, 32'd4);

    // Branch with full FIFO
    iwb_adr = 32'h100;
    iwb_stb = 1'b1;
    tick();
    check("br_flush_lvl", {29'b0, pf_lvl_o}, 32'd0);
    check("br_stb_E", {31'b0, mem_stb_o}, 32'd0);
    tick();
    check("br_stb_E1", {31'b0, mem_stb_o}, 32'd1);
    check("br_adr_E1", mem_adr_o, 32'h100);
    lat = 2;
    while (!iwb_ack_o && lat < 50) begin
      tick();
      lat++;
    end
    check("br_lat", lat, 32'd4);
    check("br_dat", iwb_dat_o, 32'h100 ^ K);
    iwb_stb = 1'b0;
    tick();

    // Branch during an outstanding 3-wait-state fetch of 0x14
    ws = 3;
    do_reset();
    fetch(32'h0, d, lat);
    check("ws3_dat0", d, K);
    fetch(32'h4, d, lat);
    check("ws3_dat4", d, 32'h4 ^ K);
    n = 0;
    while (!(mem_stb_o && mem_adr_o == 32'h14) && n < 80) begin
      tick();
      n++;
    end
    check("ws3_reach_14", {31'b0, mem_stb_o && mem_adr_o == 32'h14}, 32'd1);
    iwb_adr = 32'h200;
    iwb_stb = 1'b1;
    n = 0;
    early = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (iwb_ack_o) early = 1;
      if (mem_stb_o && mem_adr_o == 32'h14) n++;
      else break;
    end
    check("drain_hold_cycles", n, 32'd3);
    check("drain_next_stb", {31'b0, mem_stb_o}, 32'd1);
    check("drain_next_adr", mem_adr_o, 32'h200);
    check("drain_no_early_ack", {31'b0, early}, 32'd0);
    n = 0;
    while (!iwb_ack_o && n < 50) begin
      tick();
      n++;
    end
    check("drain_ack", {31'b0, iwb_ack_o}, 32'd1);
    check("drain_dat", iwb_dat_o, 32'h200 ^ K);
    iwb_stb = 1'b0;
    tick();

    // Address wrap
    ws = 0;
    do_reset();
    n = 0;
    while (pf_lvl_o != 3'd4 && n < 20) begin
      tick();
      n++;
    end
    check("wrap_prefull", {29'b0, pf_lvl_o}, 32'd4);
    log_q.delete();
    fetch(32'hFFFF_FFF8, d, lat);
    check("wrap_lat", lat, 32'd4);
    check("wrap_dat_f8", d, 32'h5A5A_FFF8);
    fetch(32'hFFFF_FFFC, d, lat);
    check("wrap_dat_fc", d, 32'h5A5A_FFFC);
    fetch(32'h0, d, lat);
    check("wrap_dat_0", d, K);
    check("wrap_log_0", log_at(0), 32'hFFFF_FFF8);
    check("wrap_log_1", log_at(1), 32'hFFFF_FFFC);
    check("wrap_log_2", log_at(2), 32'h0);
    check("wrap_log_3", log_at(3), 32'h4);

    // Asynchronous reset while fetching
    do_reset();
    iwb_adr = 32'h0;
    iwb_stb = 1'b1;
    n = 0;
    while (!iwb_ack_o && n < 20) begin
      tick();
      n++;
    end
    check("ar_pre_ack", {31'b0, iwb_ack_o}, 32'd1);
    check("ar_pre_stb", {31'b0, mem_stb_o}, 32'd1);
    #2;
    rst = 1'b1;
    iwb_stb = 1'b0;
    #1;
    check("ar_ack", {31'b0, iwb_ack_o}, 32'd0);
    check("ar_stb", {31'b0, mem_stb_o}, 32'd0);
    check("ar_adr", mem_adr_o, 32'd0);
    check("ar_dat", iwb_dat_o, 32'd0);
    check("ar_lvl", {29'b0, pf_lvl_o}, 32'd0);
    tick();
    rst = 1'b0;
    log_q.delete();
    tick();
    check("ar_restart_stb", {31'b0, mem_stb_o}, 32'd1);
    check("ar_restart_adr", mem_adr_o, 32'd0);

    // Random instruction stream with random wait states
    ws_rand = 1;
    do_reset();
    prev = 32'hFFFF_FFFC;
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(9, 0))
        0, 1:    a = $urandom();
        2:       a = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
        default: a = (prev & 32'hFFFF_FFFC) + 32'd4 + 32'($urandom_range(3, 0));
      endcase
      fetch(a, d, lat);
      check($sformatf("rnd_dat_%0d", t), d, (a & 32'hFFFF_FFFC) ^ K);
      check($sformatf("rnd_lvl_%0d", t), {31'b0, pf_lvl_o <= 3'd4}, 32'd1);
      prev = a;
      repeat ($urandom_range(2, 0)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
